// File: rtl/irrigation_interval_scheduler_if.sv
// Purpose : requester/actuator-side bundle of the irrigation interval scheduler.
// Latency : none (wires only).
// Backpressure: none; req is a level request, grant/done/busy/tick are status outputs.
// Ports   : req/dur driven by the zone controllers (master),
//           grant/done/busy/tick driven by the scheduler (slave).
interface irrigation_interval_scheduler_if #(
    parameter int N_REQ = 3,
    parameter int DUR_W = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DUR_W-1:0] dur;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   tick;

    modport master (
        output req,
        output dur,
        input  grant,
        input  done,
        input  busy,
        input  tick
    );

    modport slave (
        input  req,
        input  dur,
        output grant,
        output done,
        output busy,
        output tick
    );
endinterface

// File: rtl/irrigation_interval_scheduler.sv
// Purpose : round-robin time-sharing of one prescaled interval timer among N_REQ requesters.
// Latency : grant 1 cycle after req sampled; done 1 cycle after grant falls (2 after req for zero duration).
// Backpressure: level req; dropping req[owner] aborts the interval on the next edge without a done pulse.
// Ports   : clock, reset (sync, active-high); bus.slave carries req/dur in and grant/done/busy/tick out.
module irrigation_interval_scheduler #(
    parameter int N_REQ    = 3,
    parameter int PRESCALE = 50000000,
    parameter int DUR_W    = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    irrigation_interval_scheduler_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PC_W  = $clog2(PRESCALE);
    localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [N_REQ-1:0]  grant_q, grant_nxt;
    logic [N_REQ-1:0]  done_q, done_nxt;
    logic              busy_q, busy_nxt;
    logic [PC_W-1:0]   pre_cnt, pre_nxt;
    logic [DUR_W-1:0]  remaining, rem_nxt;
    logic [IDX_W-1:0]  last, last_nxt;
    logic [IDX_W-1:0]  winner, win_nxt;

    logic [DUR_W-1:0]  dur_arr [N_REQ];
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    logic              found;
    logic              tick;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            dur_arr[i] = bus.dur[i*DUR_W +: DUR_W];
        end
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign tick = (state == RUN) && (pre_cnt == PC_MAX);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        done_nxt  = '0;
        pre_nxt   = pre_cnt;
        rem_nxt   = remaining;
        last_nxt  = last;
        win_nxt   = winner;
        case (state)
            IDLE: begin
                pre_nxt   = '0;
                grant_nxt = '0;
                if (found) begin
                    win_nxt = pick;
                    rem_nxt = dur_arr[pick];
                    if (dur_arr[pick] != '0) begin
                        state_nxt = RUN;
                        grant_nxt = onehot(pick);
                    end else begin
                        // Zero-length interval: skip RUN, still report completion.
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (!bus.req[winner]) begin
                    // Abort outranks a coincident final tick.
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    last_nxt  = winner;
                    pre_nxt   = '0;
                end else begin
                    pre_nxt = (pre_cnt == PC_MAX) ? '0 : pre_cnt + 1'b1;
                    if (tick) begin
                        if (remaining == DUR_W'(1)) begin
                            state_nxt = DONE;
                            grant_nxt = '0;
                        end else begin
                            rem_nxt = remaining - 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                done_nxt  = onehot(winner);
                last_nxt  = winner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
        busy_nxt = (state_nxt == RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            pre_cnt   <= '0;
            remaining <= '0;
            last      <= IDX_TOP;
            winner    <= '0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            done_q    <= done_nxt;
            busy_q    <= busy_nxt;
            pre_cnt   <= pre_nxt;
            remaining <= rem_nxt;
            last      <= last_nxt;
            winner    <= win_nxt;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.tick  = tick;
endmodule

// File: tb/tb_irrigation_interval_scheduler.sv
// Purpose : directed + random check of irrigation_interval_scheduler against a cycle-count model.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_irrigation_interval_scheduler;
    localparam int N        = 3;
    localparam int PRESCALE = 4;
    localparam int DUR_W    = 4;

    logic clock;
    logic reset;

    irrigation_interval_scheduler_if #(.N_REQ(N), .DUR_W(DUR_W)) bus ();

    irrigation_interval_scheduler #(
        .N_REQ   (N),
        .PRESCALE(PRESCALE),
        .DUR_W   (DUR_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    // Model: an owner holds the timer for dur*PRESCALE cycles counted since the grant.
    int m_owner   = -1;   // requester currently holding the timer, -1 if none
    int m_closing = -1;   // requester whose completion is reported next edge
    int m_last    = N - 1;
    int m_elapsed = 0;
    int m_total   = 0;
    int e_done    = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    task automatic model(input logic rst, input logic [N-1:0] r, input logic [N*DUR_W-1:0] d);
        int dv;
        bit hit;
        e_done = 0;
        if (rst) begin
            m_owner = -1; m_closing = -1; m_last = N - 1; m_elapsed = 0; m_total = 0;
        end else if (m_closing >= 0) begin
            e_done    = 1 << m_closing;
            m_last    = m_closing;
            m_closing = -1;
        end else if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_elapsed++;
                if (m_elapsed == m_total) begin
                    m_closing = m_owner;
                    m_owner   = -1;
                end
            end
        end else begin
            hit = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (!hit && r[i]) begin
                    hit = 1'b1;
                    dv  = int'(d[i*DUR_W +: DUR_W]);
                    if (dv == 0) begin
                        m_closing = i;
                    end else begin
                        m_owner   = i;
                        m_elapsed = 0;
                        m_total   = dv * PRESCALE;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N*DUR_W-1:0] d);
        logic [7:0] e_grant;
        logic       e_busy;
        logic       e_tick;
        reset   = rst;
        bus.req = r;
        bus.dur = d;
        @(posedge clock);
        cycle++;
        model(rst, r, d);
        #1;
        e_grant = (m_owner >= 0) ? 8'(1 << m_owner) : 8'd0;
        e_busy  = (m_owner >= 0);
        e_tick  = (m_owner >= 0) && ((m_elapsed % PRESCALE) == PRESCALE - 1);
        check("grant", 8'(bus.grant), e_grant);
        check("done",  8'(bus.done),  8'(e_done));
        check("busy",  8'(bus.busy),  8'(e_busy));
        check("tick",  8'(bus.tick),  8'(e_tick));
    endtask

    task automatic run(input logic rst, input logic [N-1:0] r,
                       input int d0, input int d1, input int d2, input int n);
        logic [N*DUR_W-1:0] d;
        d = {DUR_W'(d2), DUR_W'(d1), DUR_W'(d0)};
        for (int c = 0; c < n; c++) step(rst, r, d);
    endtask

    initial begin
        logic [N-1:0]       rr;
        logic [N*DUR_W-1:0] dd;
        reset   = 1'b1;
        bus.req = '0;
        bus.dur = '0;

        // Reset state
        run(1'b1, 3'b000, 0, 0, 0, 2);
        // Basic interval: dur0=3 -> 12 grant cycles, then done
        run(1'b0, 3'b001, 3, 0, 0, 13);
        run(1'b0, 3'b000, 3, 0, 0, 4);
        // Round-robin fairness with all durations 1
        run(1'b0, 3'b111, 1, 1, 1, 22);
        run(1'b0, 3'b000, 1, 1, 1, 4);
        // Zero duration on requester 1, then pointer continues from 2
        run(1'b1, 3'b000, 0, 0, 0, 1);
        run(1'b0, 3'b010, 0, 0, 0, 1);
        run(1'b0, 3'b000, 0, 0, 0, 3);
        run(1'b0, 3'b101, 1, 1, 1, 14);
        run(1'b0, 3'b000, 1, 1, 1, 4);
        // Abort: requester 1 dropped mid-interval, pending 2 takes over
        run(1'b1, 3'b000, 0, 0, 0, 1);
        run(1'b0, 3'b110, 0, 5, 2, 7);
        run(1'b0, 3'b100, 0, 5, 2, 12);
        run(1'b0, 3'b000, 0, 5, 2, 3);
        // Reset mid-run, then 110 goes to requester 1
        run(1'b0, 3'b001, 5, 2, 2, 6);
        run(1'b1, 3'b001, 5, 2, 2, 1);
        run(1'b0, 3'b110, 5, 2, 2, 6);
        run(1'b0, 3'b000, 5, 2, 2, 12);
        // Abort coinciding with the final tick
        run(1'b1, 3'b000, 0, 0, 0, 1);
        run(1'b0, 3'b001, 1, 0, 0, 4);
        run(1'b0, 3'b000, 1, 0, 0, 3);

        // Random: slowly varying requests, short durations, rare resets
        rr = '0;
        dd = '0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) rr = N'($urandom_range(7));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5) == 0) dd[i*DUR_W +: DUR_W] = DUR_W'($urandom_range(3));
            end
            step(($urandom_range(99) == 0), rr, dd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
